// File: rtl/cpu_pkg.sv
// Shared types for the accumulator core sequencer.
// Opcodes, ALU selects, FSM states and decode bundle.
package cpu_pkg;

  localparam int PC_W = 8;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADDI = 4'h2,
    OP_SUBI = 4'h3,
    OP_ANDI = 4'h4,
    OP_ORI  = 4'h5,
    OP_XORI = 4'h6,
    OP_LD   = 4'h7,
    OP_ST   = 4'h8,
    OP_JMP  = 4'h9,
    OP_JZ   = 4'hA,
    OP_HLT  = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_PASS_IMM = 3'd0,
    ALU_ADD      = 3'd1,
    ALU_SUB      = 3'd2,
    ALU_AND      = 3'd3,
    ALU_OR       = 3'd4,
    ALU_XOR      = 3'd5,
    ALU_PASS_MEM = 3'd6
  } alu_op_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    acc_wr;
    logic    is_mem;
    logic    is_store;
    logic    is_jump;
    logic    is_cond;
    logic    is_halt;
    logic    illegal;
  } dec_t;

endpackage

// File: rtl/seq_decode.sv
// Combinational opcode decoder for the sequencer.
// Undefined opcodes flag illegal and otherwise behave as NOP.
module seq_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    unique case (1'b1)
      opcode == OP_NOP: ;
      opcode == OP_LDI: begin
        dec.acc_wr = 1'b1;
        dec.alu_op = ALU_PASS_IMM;
      end
      opcode == OP_ADDI: begin
        dec.acc_wr = 1'b1;
        dec.alu_op = ALU_ADD;
      end
      opcode == OP_SUBI: begin
        dec.acc_wr = 1'b1;
        dec.alu_op = ALU_SUB;
      end
      opcode == OP_ANDI: begin
        dec.acc_wr = 1'b1;
        dec.alu_op = ALU_AND;
      end
      opcode == OP_ORI: begin
        dec.acc_wr = 1'b1;
        dec.alu_op = ALU_OR;
      end
      opcode == OP_XORI: begin
        dec.acc_wr = 1'b1;
        dec.alu_op = ALU_XOR;
      end
      opcode == OP_LD: begin
        dec.is_mem = 1'b1;
        dec.alu_op = ALU_PASS_MEM;
      end
      opcode == OP_ST: begin
        dec.is_mem   = 1'b1;
        dec.is_store = 1'b1;
      end
      opcode == OP_JMP: dec.is_jump = 1'b1;
      opcode == OP_JZ:  dec.is_cond = 1'b1;
      opcode == OP_HLT: dec.is_halt = 1'b1;
      default:          dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seq_ctrl.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator core.
// Owns the FSM, PC, instruction register and sticky illegal flag.
module seq_ctrl
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [7:0]      instr_i,
  input  logic            instr_valid_i,
  output logic            instr_ready_o,
  input  logic            alu_zero_i,
  input  logic            mem_ack_i,
  output logic [PC_W-1:0] pc_o,
  output logic [2:0]      alu_op_o,
  output logic [3:0]      imm_o,
  output logic            acc_we_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [7:0]      mem_addr_o,
  output logic            halted_o,
  output logic            illegal_o
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q;
  logic            illegal_q;
  dec_t            dec;
  logic            take;

  seq_decode u_dec (
    .opcode (ir_q[7:4]),
    .dec    (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: begin
        if (instr_valid_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          dec.is_halt: state_d = S_HALT;
          dec.is_mem:  state_d = S_MEM;
          default:     state_d = S_EXEC;
        endcase
      end
      S_EXEC: state_d = S_FETCH;
      S_MEM: begin
        if (mem_ack_i) state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  assign take = dec.is_jump | (dec.is_cond & alu_zero_i);

  always_comb begin
    pc_d = pc_q;
    if (state_q == S_EXEC) begin
      pc_d = take ? {ir_q[3:0], 4'h0} : pc_q + 1'b1;
    end else if (state_q == S_MEM && mem_ack_i) begin
      pc_d = pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= '0;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else if (ena) begin
      pc_q <= pc_d;
      if (state_q == S_FETCH && instr_valid_i) begin
        ir_q <= instr_i;
      end
      if (state_q == S_DECODE && dec.illegal) begin
        illegal_q <= 1'b1;
      end
    end
  end

  // LD writes the accumulator in the ack cycle itself
  always_comb begin
    instr_ready_o = ena & (state_q == S_FETCH);
    acc_we_o      = ena & ((state_q == S_EXEC & dec.acc_wr) |
                           (state_q == S_MEM & ~dec.is_store & mem_ack_i));
    alu_op_o      = acc_we_o ? dec.alu_op : ALU_PASS_IMM;
    mem_req_o     = ena & (state_q == S_MEM);
    mem_we_o      = mem_req_o & dec.is_store;
    mem_addr_o    = {4'h0, ir_q[3:0]};
    imm_o         = ir_q[3:0];
    pc_o          = pc_q;
    halted_o      = (state_q == S_HALT);
    illegal_o     = illegal_q;
  end

endmodule

// File: tb/tb_seq_ctrl.sv
// Self-checking bench for seq_ctrl: directed table, corner
// sequences and randomized instructions against a reference model.
module tb_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] instr_i;
  logic       instr_valid_i;
  logic       instr_ready_o;
  logic       alu_zero_i;
  logic       mem_ack_i;
  logic [7:0] pc_o;
  logic [2:0] alu_op_o;
  logic [3:0] imm_o;
  logic       acc_we_o;
  logic       mem_req_o;
  logic       mem_we_o;
  logic [7:0] mem_addr_o;
  logic       halted_o;
  logic       illegal_o;

  int n_cmp = 0;
  int n_bad = 0;

  seq_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .instr_i       (instr_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .alu_zero_i    (alu_zero_i),
    .mem_ack_i     (mem_ack_i),
    .pc_o          (pc_o),
    .alu_op_o      (alu_op_o),
    .imm_o         (imm_o),
    .acc_we_o      (acc_we_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .halted_o      (halted_o),
    .illegal_o     (illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int nr;
    int we;
    int op;
    int req;
    int mwe;
    int stray;
    int bad_addr;
    int timeout;
    logic [7:0] pc;
  } obs_t;

  typedef struct {
    logic [7:0] ins;
    logic       z;
    int         d;
    logic [7:0] pc;
    int         nr;
    int         we;
    int         op;
    int         req;
    int         mwe;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one instruction from a sync point (negedge+1) and observe it
  // until the sequencer is ready again or halts.
  task automatic run(input logic [7:0] ins, input logic z,
                     input int d, output obs_t o);
    int g;
    o = '{default: 0, pc: 8'h00};
    g = 0;
    while (!instr_ready_o && g < 50) begin
      @(negedge clk); #1; g++;
    end
    if (!instr_ready_o) o.timeout = 1;
    instr_i = ins;
    instr_valid_i = 1'b1;
    alu_zero_i = z;
    @(posedge clk); #1;
    instr_valid_i = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req_o && o.req == d) mem_ack_i = 1'b1;
      #1;
      if (instr_ready_o) break;
      o.nr++;
      if (mem_req_o) o.req++;
      if (mem_we_o) o.mwe++;
      if (mem_req_o && mem_addr_o !== {4'h0, ins[3:0]}) o.bad_addr++;
      if (acc_we_o) begin
        o.we++;
        o.op = alu_op_o;
      end else if (alu_op_o != 3'd0) begin
        o.stray++;
      end
      if (halted_o) break;
      if (o.nr > 40) begin
        o.timeout = 1;
        break;
      end
      @(posedge clk); #1;
      mem_ack_i = 1'b0;
    end
    o.pc = pc_o;
  endtask

  // Reference: instruction-level effect from the opcode rules.
  function automatic vec_t model(input logic [7:0] ins, input logic z,
                                 input int d, input logic [7:0] pc);
    vec_t e;
    int opc;
    opc = int'(ins[7:4]);
    e.ins = ins; e.z = z; e.d = d;
    e.pc = 8'((int'(pc) + 1) % 256);
    e.nr = 2; e.we = 0; e.op = 0; e.req = 0; e.mwe = 0;
    if (opc >= 1 && opc <= 6) begin
      e.we = 1;
      e.op = opc - 1;
    end else if (opc == 7) begin
      e.nr = 2 + d; e.we = 1; e.op = 6; e.req = d + 1;
    end else if (opc == 8) begin
      e.nr = 2 + d; e.req = d + 1; e.mwe = d + 1;
    end else if (opc == 9 || (opc == 10 && z)) begin
      e.pc = 8'(int'(ins[3:0]) * 16);
    end else if (opc == 15) begin
      e.pc = pc;
    end
    return e;
  endfunction

  task automatic cmp_obs(input string nm, input obs_t o, input vec_t e);
    chk({nm, " pc"}, o.pc, e.pc);
    chk({nm, " busy"}, o.nr, e.nr);
    chk({nm, " we"}, o.we, e.we);
    chk({nm, " op"}, o.op, e.op);
    chk({nm, " req"}, o.req, e.req);
    chk({nm, " mwe"}, o.mwe, e.mwe);
    chk({nm, " stray"}, o.stray, 0);
    chk({nm, " addr"}, o.bad_addr, 0);
    chk({nm, " tmo"}, o.timeout, 0);
  endtask

  initial begin
    vec_t tbl[7];
    obs_t o;
    vec_t e;
    logic [7:0] mpc;
    logic [7:0] ins;
    logic mill;
    logic z;
    int d;
    int seen;

    tbl[0] = '{8'h21, 1'b0, 0, 8'h01, 2, 1, 1, 0, 0};
    tbl[1] = '{8'h75, 1'b0, 3, 8'h02, 5, 1, 6, 4, 0};
    tbl[2] = '{8'hA3, 1'b1, 0, 8'h30, 2, 0, 0, 0, 0};
    tbl[3] = '{8'hA3, 1'b0, 0, 8'h31, 2, 0, 0, 0, 0};
    tbl[4] = '{8'h81, 1'b0, 0, 8'h32, 2, 0, 0, 1, 1};
    tbl[5] = '{8'h14, 1'b0, 0, 8'h33, 2, 1, 0, 0, 0};
    tbl[6] = '{8'h9F, 1'b0, 0, 8'hF0, 2, 0, 0, 0, 0};

    rst_n = 1'b0; ena = 1'b1; instr_i = 8'h00;
    instr_valid_i = 1'b0; alu_zero_i = 1'b0; mem_ack_i = 1'b0;
    @(negedge clk); #1;
    chk("rst pc", pc_o, 8'h00);
    chk("rst imm", imm_o, 4'h0);
    chk("rst aluop", alu_op_o, 3'd0);
    chk("rst accwe", acc_we_o, 1'b0);
    chk("rst req", mem_req_o, 1'b0);
    chk("rst mwe", mem_we_o, 1'b0);
    chk("rst halt", halted_o, 1'b0);
    chk("rst ill", illegal_o, 1'b0);
    chk("rst rdy", instr_ready_o, 1'b1);
    ena = 1'b0; #1;
    chk("rst rdy ena0", instr_ready_o, 1'b0);
    ena = 1'b1;
    @(negedge clk); rst_n = 1'b1; #1;

    for (int i = 0; i < 7; i++) begin
      run(tbl[i].ins, tbl[i].z, tbl[i].d, o);
      cmp_obs($sformatf("vec%0d", i), o, tbl[i]);
    end
    chk("imm after jmp", imm_o, 4'hF);

    for (int i = 0; i < 16; i++) begin
      run(8'h00, 1'b0, 0, o);
      if (i == 14) chk("nop to ff", o.pc, 8'hFF);
      if (i == 15) chk("nop wrap", o.pc, 8'h00);
    end

    instr_i = 8'h82; instr_valid_i = 1'b1;
    @(posedge clk); #1;
    instr_valid_i = 1'b0;
    @(negedge clk); #1;
    chk("st dec req", mem_req_o, 1'b0);
    @(negedge clk); #1;
    chk("st req", mem_req_o, 1'b1);
    chk("st we", mem_we_o, 1'b1);
    chk("st addr", mem_addr_o, 8'h02);
    ena = 1'b0; #1;
    chk("st ena0 req", mem_req_o, 1'b0);
    chk("st ena0 we", mem_we_o, 1'b0);
    @(negedge clk);
    mem_ack_i = 1'b1; #1;
    chk("st ena0 acc", acc_we_o, 1'b0);
    chk("st ena0 pc", pc_o, 8'h00);
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    @(negedge clk);
    ena = 1'b1; #1;
    chk("st req back", mem_req_o, 1'b1);
    chk("st we back", mem_we_o, 1'b1);
    chk("st pc hold", pc_o, 8'h00);
    @(negedge clk); #1;
    chk("st still req", mem_req_o, 1'b1);
    mem_ack_i = 1'b1; #1;
    chk("st ack acc", acc_we_o, 1'b0);
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    @(negedge clk); #1;
    chk("st done rdy", instr_ready_o, 1'b1);
    chk("st done pc", pc_o, 8'h01);
    chk("st done req", mem_req_o, 1'b0);

    chk("ill clear", illegal_o, 1'b0);
    run(8'hC0, 1'b0, 0, o);
    cmp_obs("ill", o, model(8'hC0, 1'b0, 0, 8'h01));
    chk("ill set", illegal_o, 1'b1);

    mpc = 8'h02;
    mill = 1'b1;
    for (int i = 0; i < 150; i++) begin
      ins = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))};
      z = 1'($urandom_range(0, 1));
      d = $urandom_range(0, 3);
      e = model(ins, z, d, mpc);
      run(ins, z, d, o);
      cmp_obs($sformatf("rnd%0d_%02h", i, ins), o, e);
      chk($sformatf("rnd%0d ill", i), illegal_o, mill);
      mpc = e.pc;
    end

    run(8'hF0, 1'b0, 0, o);
    chk("hlt halted", halted_o, 1'b1);
    chk("hlt pc", pc_o, mpc);
    chk("hlt tmo", o.timeout, 0);
    seen = 0;
    instr_valid_i = 1'b1;
    instr_i = 8'h21;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (instr_ready_o || !halted_o || acc_we_o) seen++;
    end
    instr_valid_i = 1'b0;
    chk("hlt stays", seen, 0);
    chk("hlt pc hold", pc_o, mpc);
    rst_n = 1'b0; #1;
    chk("hlt rst halted", halted_o, 1'b0);
    chk("hlt rst ill", illegal_o, 1'b0);
    chk("hlt rst pc", pc_o, 8'h00);
    chk("hlt rst rdy", instr_ready_o, 1'b1);
    @(negedge clk); rst_n = 1'b1; #1;

    instr_i = 8'h77; instr_valid_i = 1'b1;
    @(posedge clk); #1;
    instr_valid_i = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    chk("ldrst req", mem_req_o, 1'b1);
    rst_n = 1'b0; #1;
    chk("ldrst req drop", mem_req_o, 1'b0);
    chk("ldrst rdy", instr_ready_o, 1'b1);
    @(negedge clk); rst_n = 1'b1; #1;
    run(8'h2A, 1'b0, 0, o);
    cmp_obs("post rst", o, model(8'h2A, 1'b0, 0, 8'h00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
